// File: rtl/armleocpu_mem_responder.sv
// Word-addressed on-chip RAM answering the cache master bus: single and burst
// reads/writes with registered beat-complete pulses and accept-time error checks.
module armleocpu_mem_responder #(
  parameter logic [33:0] BASE_ADDR    = 34'h0,
  parameter int unsigned DEPTH_W      = 10,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        transaction,
  input  logic [2:0]  cmd,
  output logic        transaction_done,
  output logic [2:0]  transaction_response,
  input  logic [33:0] address,
  input  logic [3:0]  burstcount,
  input  logic [31:0] wdata,
  input  logic [3:0]  wbyte_enable,
  output logic [31:0] rdata
);

  localparam logic [2:0] CMD_READ  = 3'd1;
  localparam logic [2:0] CMD_WRITE = 3'd2;
  localparam logic [2:0] RESP_OKAY    = 3'd0;
  localparam logic [2:0] RESP_ADDRERR = 3'd1;
  localparam logic [2:0] RESP_CMDERR  = 3'd2;

  localparam logic [34:0] END_ADDR  = {1'b0, BASE_ADDR} + (35'd4 << DEPTH_W);
  // RD_WAIT spends wait+1 cycles: L-1 before the first beat, L between beats
  localparam logic [3:0]  LAT_FIRST = 4'((READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0);
  localparam logic [3:0]  LAT_NEXT  = 4'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_SAMPLE,
    RD_WAIT,
    RESP,
    COOLDOWN
  } state_t;

  state_t               state_q, state_d;
  logic                 rd_q, rd_d;
  logic [DEPTH_W-1:0]   idx_q, idx_d;
  logic [3:0]           beat_q, beat_d;
  logic [3:0]           burst_q, burst_d;
  logic [3:0]           wait_q, wait_d;
  logic                 done_q, done_d;
  logic [2:0]           resp_q, resp_d;
  logic [31:0]          rdata_q;

  logic [31:0]          mem [2**DEPTH_W];
  logic                 mem_we, mem_re;
  logic [DEPTH_W-1:0]   mem_addr;

  logic [34:0]          last_ext;
  logic [33:0]          addr_off;
  logic [DEPTH_W-1:0]   acc_idx;
  logic [2:0]           acc_err;

  always_comb begin
    last_ext = {1'b0, address} + {29'b0, burstcount, 2'b00};
    addr_off = address - BASE_ADDR;
    acc_idx  = DEPTH_W'(addr_off >> 2);
    if (cmd != CMD_READ && cmd != CMD_WRITE)
      acc_err = RESP_CMDERR;
    else if (address[1:0] != 2'b00 || address < BASE_ADDR || last_ext >= END_ADDR)
      acc_err = RESP_ADDRERR;
    else
      acc_err = RESP_OKAY;
  end

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    idx_d    = idx_q;
    beat_d   = beat_q;
    burst_d  = burst_q;
    wait_d   = wait_q;
    done_d   = 1'b0;
    resp_d   = RESP_OKAY;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = idx_q;
    unique case (state_q)
      IDLE: begin
        if (transaction) begin
          rd_d     = (cmd == CMD_READ);
          idx_d    = acc_idx;
          beat_d   = '0;
          burst_d  = burstcount;
          mem_addr = acc_idx;
          if (acc_err != RESP_OKAY) begin
            // an error answers once, whatever the burst length
            burst_d = '0;
            state_d = RESP;
            done_d  = 1'b1;
            resp_d  = acc_err;
          end else if (cmd == CMD_WRITE) begin
            mem_we  = 1'b1;
            state_d = RESP;
            done_d  = 1'b1;
          end else if (READ_LATENCY == 1) begin
            mem_re  = 1'b1;
            state_d = RESP;
            done_d  = 1'b1;
          end else begin
            wait_d  = LAT_FIRST;
            state_d = RD_WAIT;
          end
        end
      end
      WR_SAMPLE: begin
        mem_we  = 1'b1;
        state_d = RESP;
        done_d  = 1'b1;
      end
      RD_WAIT: begin
        if (wait_q == '0) begin
          mem_re  = 1'b1;
          state_d = RESP;
          done_d  = 1'b1;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      RESP: begin
        if (beat_q == burst_q) begin
          state_d = COOLDOWN;
        end else begin
          beat_d = beat_q + 4'd1;
          idx_d  = idx_q + 1'b1;
          if (rd_q) begin
            wait_d  = LAT_NEXT;
            state_d = RD_WAIT;
          end else begin
            state_d = WR_SAMPLE;
          end
        end
      end
      COOLDOWN: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (rst) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      idx_q   <= '0;
      beat_q  <= '0;
      burst_q <= '0;
      wait_q  <= '0;
      done_q  <= 1'b0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      resp_q  <= resp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wbyte_enable[b])
          mem[mem_addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rdata_q <= '0;
    else
      rdata_q <= mem_re ? mem[mem_addr] : '0;
  end

  assign transaction_done     = done_q;
  assign transaction_response = resp_q;
  assign rdata                = rdata_q;

endmodule

// File: doc/armleocpu_mem_responder.md
Name: armleocpu_mem_responder

Overview:
- Word-addressed on-chip memory that sits on the responder end of the cache master bus (transaction/cmd/address/burstcount/wdata/wbyte_enable → transaction_done/transaction_response/rdata).
- Serves single and burst reads/writes from either cache port.
- Used as boot RAM and as the bench memory model behind armleocpu.

Parameters:
- BASE_ADDR, 34'h0, byte address of word 0; must be 4-byte aligned.
- DEPTH_W, 10, log2 of memory depth in 32-bit words.
- READ_LATENCY, 1, cycles from beat start to read done; legal range 1..15.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- transaction  in  1  master request; held high for the whole burst.
- cmd  in  3  3'd1 READ, 3'd2 WRITE; any other value is illegal.
- transaction_done  out  1  one-cycle beat-complete pulse.
- transaction_response  out  3  3'd0 OKAY, 3'd1 ADDRERR, 3'd2 CMDERR; valid only when transaction_done=1, else 0.
- address  in  34  byte address of beat 0; stable while transaction=1.
- burstcount  in  4  number of beats minus 1 (1..16 beats); stable while transaction=1.
- wdata  in  32  write data for the current beat.
- wbyte_enable  in  4  per-byte write lane enables.
- rdata  out  32  read data; valid only when transaction_done=1 on a READ with OKAY, else 0.

Behaviour:
- Reset:
  - transaction_done=0, transaction_response=0, rdata=0, state=IDLE, counters=0.
  - Memory contents are not cleared.
- States: IDLE, WR_SAMPLE, RD_WAIT, RESP, COOLDOWN. transaction_done is registered and high only in RESP.
- Accept: in IDLE with transaction=1 (cycle T), latch cmd, word index, beat count, and compute the error condition.
- Error priority, checked once at accept:
  - Illegal cmd → CMDERR.
  - Else address[1:0]!=0 → ADDRERR.
  - Else address<BASE_ADDR → ADDRERR.
  - Else address+4*burstcount ≥ BASE_ADDR+4*2^DEPTH_W → ADDRERR. Compute with 35-bit arithmetic so there is no wrap.
  - On error: RESP at T+1 with the error code, a single done pulse regardless of burstcount, no memory write, rdata=0.
- WRITE:
  - At the accept edge, capture wdata and write mem[idx] under wbyte_enable; disabled lanes are kept.
  - Done/OKAY at T+1.
  - Each following beat: WR_SAMPLE for 1 cycle (captures wdata and writes at its closing edge), then RESP.
  - Beats complete at T+1, T+3, T+5, …
  - The master changes wdata in the cycle after each done.
  - wbyte_enable=0 is legal: OKAY, no change.
- READ:
  - RD_WAIT counts so the first done lands at T+READ_LATENCY.
  - Subsequent dones every READ_LATENCY+1 cycles (at least one idle cycle between pulses).
  - rdata=mem[idx+k] in the beat-k RESP cycle.
  - wbyte_enable and wdata are ignored.
- Beat index k increments after each RESP.
- Final beat:
  - After the last RESP (cycle D): COOLDOWN at D+1, where transaction is ignored; IDLE at D+2.
  - The master must deassert transaction by D+1.
  - Back-to-back transactions are accepted at D+2 at the earliest.
- transaction dropped mid-burst: a protocol violation. The responder finishes the remaining beats, and writes use whatever wdata is present.
- Reset mid-burst:
  - Next cycle is IDLE with done=0.
  - Already-written beats persist; no further beats are written.
- Memory: single array of 2^DEPTH_W × 32 bits, one read or write per cycle, inferred as synchronous RAM (read registered into rdata).

Test Plan:
- Single write/read, READ_LATENCY=1: WRITE addr BASE+0x10, burstcount 0, wdata 32'hDEADBEEF, be 4'hF → done at T+1, response 0. Then READ same address → done at T'+1, rdata 32'hDEADBEEF.
- Burst read, READ_LATENCY=2: preload words 4..7 with 1,2,3,4; READ BASE+0x10, burstcount 3 → dones at T+2, T+5, T+8, T+11 with rdata 1,2,3,4. COOLDOWN at T+12; a new request at T+12 is not accepted until T+13.
- Byte lanes: word=32'h11223344; WRITE wdata 32'hAABBCCDD, be 4'b0101 → readback 32'h11BB33DD.
- Errors:
  - WRITE at BASE+4*2^DEPTH_W-8 with burstcount 3 → single done at T+1, response 1, last two in-range words unchanged.
  - READ at BASE+0x2 → response 1, rdata 0.
  - cmd 3'd3 → response 2.
- Reset mid-burst: 4-beat WRITE of A,B,C,D, rst asserted the cycle after the 2nd done → done=0 next cycle. Words 0,1 = A,B; words 2,3 unchanged; a new READ is accepted normally.
- Address upper bound: READ of the last word (BASE+4*(2^DEPTH_W-1)), burstcount 0 → OKAY. The same read with burstcount 1 → ADDRERR.
